// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response and RAM port bundle for mem_access_ctrl
//   req_valid, req_op[2:0], req_addr[31:0], req_wdata[31:0]  requester -> controller
//   req_ready                                                 controller -> requester
//   resp_valid, resp_rdata[31:0], resp_err                    controller -> requester
//   ram_ce, ram_we, ram_addr[31:0], ram_wdata[31:0], ram_sel[3:0]  controller -> RAM
//   ram_rdata[31:0]                                           RAM -> controller
interface mem_access_ctrl_if;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_ce;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_sel;
   logic [31:0] ram_rdata;
   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, ram_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             ram_ce, ram_we, ram_addr, ram_wdata, ram_sel
   );
   modport master (
      output req_valid, req_op, req_addr, req_wdata, ram_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             ram_ce, ram_we, ram_addr, ram_wdata, ram_sel
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store controller between the MEM stage and a byte-addressed data RAM
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mem_access_ctrl_if.slave: request handshake (req_*), one-cycle completion
//          pulse (resp_*), and the RAM port (ram_*); SH is issued as two byte writes
module mem_access_ctrl #(
   parameter int MEM_BYTES = 1000
) (
   input logic               clk,
   input logic               rst_n,
   mem_access_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESP} state_t;
   localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
                          OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;
   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  lo_q, lo_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        ram_ce_q, ram_ce_d;
   logic        ram_we_q, ram_we_d;
   logic [3:0]  ram_sel_q, ram_sel_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdata_q, ram_wdata_d;
   logic        wide, half, bad;
   logic [32:0] last_byte;
   logic [31:0] ext;
   assign wide = bus.req_op == OP_LW || bus.req_op == OP_SW;
   assign half = bus.req_op == OP_LH || bus.req_op == OP_LHU || bus.req_op == OP_SH;
   // 33-bit end address so requests near 2^32 cannot wrap into the legal range
   assign last_byte = {1'b0, bus.req_addr} + (wide ? 33'd3 : half ? 33'd1 : 33'd0);
   assign bad = (wide && bus.req_addr[1:0] != 2'b00) || (half && bus.req_addr[0])
             || last_byte >= 33'(MEM_BYTES);
   assign ext = op_q == OP_LB  ? {{24{bus.ram_rdata[31]}}, bus.ram_rdata[31:24]} :
                op_q == OP_LBU ? {24'd0, bus.ram_rdata[31:24]} :
                op_q == OP_LH  ? {{16{bus.ram_rdata[31]}}, bus.ram_rdata[31:16]} :
                op_q == OP_LHU ? {16'd0, bus.ram_rdata[31:16]} :
                op_q == OP_LW  ? bus.ram_rdata : 32'd0;
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      lo_d         = lo_q;
      err_d        = err_q;
      rdata_d      = rdata_q;
      resp_valid_d = 1'b0;
      ram_ce_d     = 1'b0;
      ram_we_d     = 1'b0;
      ram_sel_d    = 4'd0;
      ram_addr_d   = 32'd0;
      ram_wdata_d  = 32'd0;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            op_d         = bus.req_op;
            addr_d       = bus.req_addr;
            lo_d         = bus.req_wdata[7:0];
            err_d        = bad;
            rdata_d      = 32'd0;
            state_d      = bad ? RESP : ACCESS;
            resp_valid_d = bad;
            // RAM outputs are registered here so ACCESS drives them straight from flops
            ram_ce_d     = !bad;
            ram_we_d     = !bad && bus.req_op >= OP_SB;
            ram_sel_d    = {3'b000, !bad && bus.req_op == OP_SW};
            ram_addr_d   = bad ? 32'd0 : bus.req_addr;
            ram_wdata_d  = bad                 ? 32'd0 :
                           bus.req_op == OP_SW ? bus.req_wdata :
                           bus.req_op == OP_SB ? {bus.req_wdata[7:0], 24'd0} :
                           bus.req_op == OP_SH ? {bus.req_wdata[15:8], 24'd0} : 32'd0;
         end
         ACCESS: if (op_q == OP_SH) begin
            state_d     = ACCESS2;
            ram_ce_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = addr_q + 32'd1;
            ram_wdata_d = {lo_q, 24'd0};
         end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            rdata_d      = ext;
         end
         ACCESS2: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= 3'd0;
         addr_q       <= 32'd0;
         lo_q         <= 8'd0;
         err_q        <= 1'b0;
         rdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         ram_ce_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_sel_q    <= 4'd0;
         ram_addr_q   <= 32'd0;
         ram_wdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         lo_q         <= lo_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
         resp_valid_q <= resp_valid_d;
         ram_ce_q     <= ram_ce_d;
         ram_we_q     <= ram_we_d;
         ram_sel_q    <= ram_sel_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
      end
   end
   assign bus.req_ready  = state_q == IDLE;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.ram_ce     = ram_ce_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_sel    = ram_sel_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed stimulus against a byte-array reference model of mem_access_ctrl
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   mem_access_ctrl_if bus();
   mem_access_ctrl #(.MEM_BYTES(1000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      logic        err;
      int          due;
      int          nce;
   } exp_t;
   exp_t        q[$];
   logic [7:0]  ram [0:1023];
   logic [7:0]  mdl [0:1023];
   logic [9:0]  ra;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          ce_cnt = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   assign ra = bus.ram_addr[9:0];
   assign bus.ram_rdata = {ram[ra], ram[ra + 10'd1], ram[ra + 10'd2], ram[ra + 10'd3]};
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk)
      if (bus.ram_ce && bus.ram_we) begin
         if (bus.ram_sel == 4'b0001) begin
            ram[ra]         <= bus.ram_wdata[31:24];
            ram[ra + 10'd1] <= bus.ram_wdata[23:16];
            ram[ra + 10'd2] <= bus.ram_wdata[15:8];
            ram[ra + 10'd3] <= bus.ram_wdata[7:0];
         end else
            ram[ra] <= bus.ram_wdata[31:24];
      end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // Reference model: decides legality and the load result from the byte image, applies stores.
   task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      exp_t   e;
      int     s;
      longint last;
      s = (op == 3'd4 || op == 3'd7) ? 4 : (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 : 1;
      last = longint'(a) + s - 1;
      e.op = op; e.a = a; e.d = d; e.rd = 32'd0;
      e.err = (a % s != 0) || last >= 1000;
      e.due = cyc; e.nce = 0;
      if (!e.err) begin
         e.due = cyc + (op == 3'd6 ? 2 : 1);
         e.nce = op == 3'd6 ? 2 : 1;
         case (op)
            3'd0: e.rd = {{24{mdl[a][7]}}, mdl[a]};
            3'd1: e.rd = {24'd0, mdl[a]};
            3'd2: e.rd = {{16{mdl[a][7]}}, mdl[a], mdl[a + 1]};
            3'd3: e.rd = {16'd0, mdl[a], mdl[a + 1]};
            3'd4: e.rd = {mdl[a], mdl[a + 1], mdl[a + 2], mdl[a + 3]};
            3'd5: mdl[a] = d[7:0];
            3'd6: begin mdl[a] = d[15:8]; mdl[a + 1] = d[7:0]; end
            default: begin
               mdl[a] = d[31:24]; mdl[a + 1] = d[23:16]; mdl[a + 2] = d[15:8]; mdl[a + 3] = d[7:0];
            end
         endcase
      end
      q.push_back(e);
   endtask
   always @(negedge clk) begin
      if (!rst_n) ce_cnt = 0;
      else begin
         chk("req_ready", 32'(bus.req_ready), 32'(q.size() == 0 && !bus.resp_valid));
         if (bus.ram_ce) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL ram_ce: got 1 with nothing outstanding, expected 0 (cycle %0d)", cyc);
            end else begin
               chk("ce_legal", 32'(q[0].err), 32'd0);
               chk("ram_we", 32'(bus.ram_we), 32'(q[0].op >= 3'd5));
               chk("ram_sel", 32'(bus.ram_sel), q[0].op == 3'd7 ? 32'd1 : 32'd0);
               chk("ram_addr", bus.ram_addr, q[0].a + 32'(ce_cnt));
               if (q[0].op == 3'd7) chk("ram_wdata", bus.ram_wdata, q[0].d);
               else if (q[0].op == 3'd5) chk("ram_wbyte", 32'(bus.ram_wdata[31:24]), 32'(q[0].d[7:0]));
               else if (q[0].op == 3'd6)
                  chk("ram_wbyte", 32'(bus.ram_wdata[31:24]), ce_cnt == 0 ? 32'(q[0].d[15:8]) : 32'(q[0].d[7:0]));
               ce_cnt++;
            end
         end else
            chk("ram_idle", 32'(|{bus.ram_we, bus.ram_sel, bus.ram_addr, bus.ram_wdata}), 32'd0);
         if (bus.resp_valid) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL resp_spurious: got resp_valid 1, expected 0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("resp_cycle", 32'(cyc), 32'(e.due));
               chk("resp_err", 32'(bus.resp_err), 32'(e.err));
               chk("resp_rdata", bus.resp_rdata, e.rd);
               chk("ce_cycles", 32'(ce_cnt), 32'(e.nce));
               ce_cnt = 0;
               last_rdata = bus.resp_rdata;
               last_err = bus.resp_err;
            end
         end else if (q.size() != 0 && cyc > q[0].due) begin
            tests++; fails++;
            $display("FAIL resp_late: got no response, expected one at cycle %0d (now %0d)", q[0].due, cyc);
            void'(q.pop_front());
            ce_cnt = 0;
         end
      end
   end
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = d;
      while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.req_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: got req_ready 0 for 50 cycles, expected 1");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      push(op, a, d);
   endtask
   task automatic wait_done();
      int n = 0;
      while ((q.size() != 0 || !bus.req_ready) && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin
         tests++; fails++;
         $display("FAIL done_timeout: got %0d outstanding after 50 cycles, expected 0", q.size());
      end
   endtask
   task automatic lit(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
      last_rdata = 32'hxxxx_xxxx;
      last_err = 1'bx;
      send(op, a, d);
      wait_done();
      chk({nm, "_rdata"}, last_rdata, exp_rd);
      chk({nm, "_err"}, 32'(last_err), 32'(exp_err));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end
   initial begin
      int diff = 0;
      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
      for (int i = 0; i < 1024; i++) begin ram[i] = 8'd0; mdl[i] = 8'd0; end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_ce", 32'(bus.ram_ce), 32'd0);
      chk("rst_resp", 32'(bus.resp_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      lit("sw8", 3'd7, 32'd8, 32'h1122_3344, 32'h0, 1'b0);
      lit("lw8", 3'd4, 32'd8, 32'h0, 32'h1122_3344, 1'b0);
      lit("sb12", 3'd5, 32'd12, 32'h0000_0080, 32'h0, 1'b0);
      lit("lb12", 3'd0, 32'd12, 32'h0, 32'hFFFF_FF80, 1'b0);
      lit("lbu12", 3'd1, 32'd12, 32'h0, 32'h0000_0080, 1'b0);
      lit("sh20", 3'd6, 32'd20, 32'h0000_BEEF, 32'h0, 1'b0);
      chk("ram20", 32'(ram[20]), 32'hBE);
      chk("ram21", 32'(ram[21]), 32'hEF);
      lit("lh20", 3'd2, 32'd20, 32'h0, 32'hFFFF_BEEF, 1'b0);
      lit("lhu20", 3'd3, 32'd20, 32'h0, 32'h0000_BEEF, 1'b0);
      lit("lw6", 3'd4, 32'd6, 32'h0, 32'h0, 1'b1);
      lit("sh3", 3'd6, 32'd3, 32'h1234, 32'h0, 1'b1);
      lit("lw997", 3'd4, 32'd997, 32'h0, 32'h0, 1'b1);
      lit("lb999", 3'd0, 32'd999, 32'h0, 32'h0, 1'b0);
      lit("lw996", 3'd4, 32'd996, 32'h0, 32'h0, 1'b0);
      lit("lb1000", 3'd0, 32'd1000, 32'h0, 32'h0, 1'b1);
      lit("swwrap", 3'd7, 32'hFFFF_FFFC, 32'h5555_AAAA, 32'h0, 1'b1);
      send(3'd6, 32'd40, 32'h0000_1234);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ce", 32'(bus.ram_ce), 32'd0);
      chk("mid_rst_resp", 32'(bus.resp_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_ram40", 32'(ram[40]), 32'h12);
      chk("mid_rst_ram41", 32'(ram[41]), 32'h00);
      q.delete();
      mdl[41] = 8'h00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      lit("lh40", 3'd2, 32'd40, 32'h0, 32'h0000_1200, 1'b0);
      send(3'd4, 32'd8, 32'h0);
      send(3'd7, 32'd24, 32'hA5A5_0F0F);
      send(3'd6, 32'd28, 32'h0000_8001);
      send(3'd4, 32'd24, 32'h0);
      send(3'd2, 32'd28, 32'h0);
      wait_done();
      chk("stream_last", last_rdata, 32'hFFFF_8001);
      for (int i = 0; i < 1000; i++) if (ram[i] !== mdl[i]) diff++;
      chk("mem_image", 32'(diff), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
